// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light request path: request codes,
// sequencer state encoding and the fixed-priority arbitration helpers.
package traffic_pkg;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_SIDE = 2'b01;
    localparam logic [1:0] REQ_PED  = 2'b10;
    localparam logic [1:0] REQ_EMG  = 2'b11;

    typedef enum logic [2:0] {
        S_OFF,
        S_INIT,
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    // Pending vector is {emg, ped, side}; emergency wins, then pedestrian.
    function automatic logic [1:0] arbitrate(input logic [2:0] req);
        if (req[2]) return REQ_EMG;
        if (req[1]) return REQ_PED;
        if (req[0]) return REQ_SIDE;
        return REQ_NONE;
    endfunction

    function automatic logic [2:0] code_mask(input logic [1:0] code);
        case (code)
            REQ_SIDE: return 3'b001;
            REQ_PED:  return 3'b010;
            REQ_EMG:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/traffic_debounce.sv
// Two-flop synchronizer plus consecutive-sample debouncer for one raw sensor;
// emits the debounced level and a one-cycle pulse when that level rises.
module traffic_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CW         = 8
) (
    input  logic clk,
    input  logic res_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // NOTE: every register here is updated with <= so all flops sample the
    // pre-edge values together; a blocking = would collapse the synchronizer.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                level <= sync_2;
                rise  <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_request_sequencer.sv
// Debounces the three sensors, latches them as pending requests and issues
// them to the light controller one at a time with a fixed dwell and gap.
module traffic_request_sequencer
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int GAP_CYCLES  = 2,
    parameter int INIT_CYCLES = 8,
    parameter int CW          = 8
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       sens_side,
    input  logic       sens_ped,
    input  logic       sens_emg,
    input  logic       sys_on,
    output logic [1:0] in_code,
    output logic       en,
    output logic [2:0] pending
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    lvl;
    logic [2:0]    rise;
    logic [2:0]    clr;
    logic          sys_1;
    logic          sys_on_s;
    logic          emg_extend;

    traffic_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb_side (
        .clk(clk), .res_n(res_n), .raw(sens_side), .level(lvl[0]), .rise(rise[0])
    );
    traffic_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb_ped (
        .clk(clk), .res_n(res_n), .raw(sens_ped), .level(lvl[1]), .rise(rise[1])
    );
    traffic_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb_emg (
        .clk(clk), .res_n(res_n), .raw(sens_emg), .level(lvl[2]), .rise(rise[2])
    );

    // The switch is presumed on out of reset so the init count starts at once;
    // a genuinely low switch still reaches S_OFF after the normal sync latency.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sys_1    <= 1'b1;
            sys_on_s <= 1'b1;
        end else begin
            sys_1    <= sys_on;
            sys_on_s <= sys_1;
        end
    end

    // NOTE: defaults first so every path assigns clr and no latch is inferred.
    always_comb begin
        clr        = 3'b000;
        emg_extend = (in_code == REQ_EMG) && lvl[2];
        if (state == S_HOLD && cnt == HOLD_LAST && !emg_extend) begin
            clr = code_mask(in_code);
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= S_INIT;
            cnt     <= '0;
            in_code <= REQ_NONE;
            en      <= 1'b0;
            pending <= 3'b000;
        end else if (!sys_on_s) begin
            state   <= S_OFF;
            cnt     <= '0;
            in_code <= REQ_NONE;
            en      <= 1'b0;
            pending <= 3'b000;
        end else begin
            // Enable follows the settled state, so it rises one cycle after S_IDLE.
            en      <= (state == S_IDLE) || (state == S_HOLD) || (state == S_GAP);
            pending <= (pending & ~clr) | rise;
            case (state)
                S_OFF: begin
                    state <= S_INIT;
                    cnt   <= '0;
                end
                S_INIT: begin
                    if (cnt == INIT_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (|pending) begin
                        state   <= S_HOLD;
                        in_code <= arbitrate(pending);
                        cnt     <= '0;
                    end
                end
                S_HOLD: begin
                    if (pending[2] && in_code != REQ_EMG) begin
                        in_code <= REQ_EMG;
                        cnt     <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (!emg_extend) begin
                            state   <= S_GAP;
                            in_code <= REQ_NONE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (|pending) begin
                            state   <= S_HOLD;
                            in_code <= arbitrate(pending);
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= S_INIT;
                    cnt     <= '0;
                    in_code <= REQ_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_request_sequencer.sv
// Directed bench for traffic_request_sequencer with default parameters;
// expected values are cycle counts worked out by hand from sensor rise times.
module tb_traffic_request_sequencer;

    logic       clk = 1'b0;
    logic       res_n;
    logic       sens_side;
    logic       sens_ped;
    logic       sens_emg;
    logic       sys_on;
    logic [1:0] in_code;
    logic       en;
    logic [2:0] pending;

    int checks   = 0;
    int failures = 0;

    traffic_request_sequencer dut (
        .clk(clk), .res_n(res_n), .sens_side(sens_side), .sens_ped(sens_ped),
        .sens_emg(sens_emg), .sys_on(sys_on), .in_code(in_code), .en(en),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 ns past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        res_n = 1'b0; sys_on = 1'b1;
        sens_side = 1'b0; sens_ped = 1'b0; sens_emg = 1'b0;

        // Reset and power-up init count
        edges(2);
        check("rst_en", en, 0);
        check("rst_code", in_code, 0);
        check("rst_pend", pending, 0);
        res_n = 1'b1;
        edges(1);  check("init_e1_en", en, 0);
        edges(7);  check("init_e8_en", en, 0);
        edges(1);  check("init_e9_en", en, 1);
        check("init_code", in_code, 0);
        check("init_pend", pending, 0);

        // 3-cycle glitch on side sensor is filtered
        sens_side = 1'b1;
        edges(3);  sens_side = 1'b0;
        edges(12);
        check("glitch_pend", pending, 0);
        check("glitch_code", in_code, 0);

        // Side request from idle
        sens_side = 1'b1;
        edges(6);  check("side_e6_pend", pending, 3'b000);
        edges(1);  check("side_e7_pend", pending, 3'b001);
        check("side_e7_code", in_code, 0);
        edges(1);  check("side_e8_code", in_code, 1);
        edges(2);  sens_side = 1'b0;
        edges(7);  check("side_e17_code", in_code, 1);
        edges(1);  check("side_e18_code", in_code, 0);
        check("side_e18_pend", pending, 0);
        edges(2);  check("side_e20_code", in_code, 0);
        edges(10);

        // Side and ped together: ped first, gap, then side
        sens_side = 1'b1; sens_ped = 1'b1;
        edges(7);  check("both_e7_pend", pending, 3'b011);
        edges(1);  check("both_e8_code", in_code, 2);
        edges(4);  sens_side = 1'b0; sens_ped = 1'b0;
        edges(5);  check("both_e17_code", in_code, 2);
        edges(1);  check("both_e18_code", in_code, 0);
        check("both_e18_pend", pending, 3'b001);
        edges(1);  check("both_e19_code", in_code, 0);
        edges(1);  check("both_e20_code", in_code, 1);
        edges(9);  check("both_e29_code", in_code, 1);
        edges(1);  check("both_e30_code", in_code, 0);
        check("both_e30_pend", pending, 0);
        edges(10);

        // Emergency preempts a ped hold and is extended while still present
        sens_ped = 1'b1;
        edges(8);  check("emg_e8_code", in_code, 2);
        edges(1);  sens_emg = 1'b1;
        edges(6);  sens_ped = 1'b0;
        edges(1);  check("emg_e16_pend", pending, 3'b110);
        check("emg_e16_code", in_code, 2);
        edges(1);  check("emg_e17_code", in_code, 3);
        edges(7);  sens_emg = 1'b0;
        edges(12); check("emg_e36_code", in_code, 3);
        edges(1);  check("emg_e37_code", in_code, 0);
        check("emg_e37_pend", pending, 3'b010);
        edges(1);  check("emg_e38_code", in_code, 0);
        edges(1);  check("emg_e39_code", in_code, 2);
        edges(9);  check("emg_e48_code", in_code, 2);
        edges(1);  check("emg_e49_code", in_code, 0);
        check("emg_e49_pend", pending, 0);
        edges(10);

        // sys_on dropped mid-hold, then restored with the sensor still high
        sens_side = 1'b1;
        edges(8);  check("off_hold_code", in_code, 1);
        edges(2);  sys_on = 1'b0;
        edges(2);  check("off_e2_en", en, 1);
        check("off_e2_code", in_code, 1);
        edges(1);  check("off_e3_en", en, 0);
        check("off_e3_code", in_code, 0);
        check("off_e3_pend", pending, 0);
        edges(5);  check("off_held_pend", pending, 0);
        sys_on = 1'b1;
        edges(11); check("on_e11_en", en, 0);
        edges(1);  check("on_e12_en", en, 1);
        check("on_e12_code", in_code, 0);
        edges(3);  check("on_stale_code", in_code, 0);
        check("on_stale_pend", pending, 0);
        sens_side = 1'b0;
        edges(10);

        // Asynchronous reset between clock edges during a hold
        sens_side = 1'b1;
        edges(10); check("arst_pre_code", in_code, 1);
        #1 res_n = 1'b0;
        #1;
        check("arst_en", en, 0);
        check("arst_code", in_code, 0);
        check("arst_pend", pending, 0);
        sens_side = 1'b0;
        edges(2);
        res_n = 1'b1;
        edges(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_request_sequencer.md
# traffic_request_sequencer

Upstream stage of the traffic-light controller. Synchronizes and debounces raw side-road, pedestrian and emergency sensors and latches them as pending requests. Arbitrates the pending requests by priority and drives the controller's 2-bit request code `in_code` and its enable `en`, holding each code for a bounded dwell. Replaces ad-hoc stimulus on the controller's `in`/`en` pins with a clean, registered, cycle-deterministic request stream.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples required before a debounced level changes.
- `HOLD_CYCLES`, default 10: cycles a granted request code is held on `in_code`.
- `GAP_CYCLES`, default 2: minimum cycles of `REQ_NONE` between two grants.
- `INIT_CYCLES`, default 8: cycles `en` stays low after reset or after `sys_on` returns high.
- `CW`, default 8: width of all internal counters; all cycle parameters must satisfy 1 ≤ value < 2^CW.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `res_n`  in  1  reset, asynchronous, active-low.
- `sens_side`  in  1  raw side-road vehicle sensor, asynchronous level.
- `sens_ped`  in  1  raw pedestrian button, asynchronous level.
- `sens_emg`  in  1  raw emergency-vehicle detector, asynchronous level.
- `sys_on`  in  1  raw system-enable switch, asynchronous level; 2-FF synchronized only, no debounce.
- `in_code`  out  2  request code to the controller: 00 none, 01 side, 10 ped, 11 emergency.
- `en`  out  1  controller enable.
- `pending`  out  3  status: {emg, ped, side} latched requests.

## Operation
- Reset (`res_n` low, any time): `in_code` = 00, `en` = 0, `pending` = 000, all counters 0, debounced levels 0, state `S_INIT`.
- Each sensor: 2-FF synchronizer, then debounce counter; the debounced level takes the synchronized value once the value has differed from it for `DEB_CYCLES` consecutive cycles. Any mismatch-free sample resets the counter.
- A rising edge of a debounced level sets the matching `pending` bit the following cycle.
- Priority: emg > ped > side.
- `S_INIT`: `en` = 0, `in_code` = 00; counts `INIT_CYCLES`, then `S_IDLE`. Pending bits still latch.
- `S_IDLE`: `en` = 1, `in_code` = 00. If any `pending` bit is set, the next cycle enters `S_HOLD` with `in_code` = the highest-priority pending code, and the hold counter is loaded.
- `S_HOLD`: holds the code for `HOLD_CYCLES` cycles. On completion, the serviced `pending` bit is cleared and the state goes to `S_GAP` with `in_code` = 00. Exception: an emergency hold whose debounced `sens_emg` is still high restarts the hold instead and stays at code 11.
- `S_GAP`: `in_code` = 00 for `GAP_CYCLES` cycles, then `S_IDLE`.
- Preemption: an emergency pending during a side or ped hold switches `in_code` to 11 the next cycle and restarts the hold counter. The preempted bit stays pending and is served after the gap.
- Synchronized `sys_on` low, from any state: next cycle `S_OFF`, with `en` = 0, `in_code` = 00, `pending` cleared and held clear. When `sys_on` goes high, enter `S_INIT`.
- Set/clear collision: a new rising edge on the same source in the cycle its bit is cleared leaves the bit set. An edge on an already-pending source is merged and not counted twice.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Sensor rise to `pending` set: 2 sync + `DEB_CYCLES` + 1 = 7 edges with defaults.
- `pending` set in `S_IDLE` to `in_code` valid: 1 edge.
- Sensor rise to `in_code` change from idle: 8 edges with defaults.
- Code dwell: exactly `HOLD_CYCLES` cycles. Gap: exactly `GAP_CYCLES` cycles.
- `sys_on` fall to `en` low: 2 sync + 1 = 3 edges.
- After reset release: `en` rises `INIT_CYCLES` + 1 edges later, provided `sys_on` is high (sync latency included).
- Counters never wrap; terminal compare is `== param-1`.

## Structure
- Shared package `traffic_pkg`:
  - request-code localparams `REQ_NONE`/`REQ_SIDE`/`REQ_PED`/`REQ_EMG` (00/01/10/11), also used by the controller;
  - state encoding `S_OFF`, `S_INIT`, `S_IDLE`, `S_HOLD`, `S_GAP`.
- Sub-module `traffic_debounce` (parameters `DEB_CYCLES`, `CW`): synchronizer, debounce counter, debounced level, rise pulse. Instantiated three times.
- Top level: pending register, priority arbiter, FSM, hold/gap/init counter.

## Test plan
- Reset, `sys_on` = 1, no sensors: `en` = 0 for 9 edges then 1; `in_code` stays 00; `pending` = 000.
- `sens_side` pulse of 3 cycles: never debounced, `pending` stays 000. `sens_side` high for 10 cycles from idle: `pending` = 001 at edge 7, `in_code` = 01 at edge 8 for exactly 10 cycles, then 00 for 2 cycles, `pending` = 000.
- `sens_side` and `sens_ped` asserted together: `in_code` 10 for 10 cycles, 00 for 2 cycles, 01 for 10 cycles, then 00.
- Ped hold in progress, `sens_emg` asserted for 15 cycles: `in_code` goes to 11 one edge after `pending`[2] sets. It stays 11 while debounced emg is high and for at least 10 cycles, then gap, then 10 resumes for a full 10 cycles.
- `sys_on` dropped mid-hold: 3 edges later `en` = 0, `in_code` = 00, `pending` = 000. When raised again: `en` returns after init count, no stale request issued.
- `res_n` asserted asynchronously mid-hold (between clock edges): outputs go to 00/0/000 immediately, without waiting for `clk`.
